// File: rtl/fft4_pkg.sv
// fft4_pkg
// Shared definitions for the 4-point FFT frame controller and its core:
//   IN_W_DEF / OUT_W_DEF - default sample and bin widths
//   state_t              - frame controller states (LOAD, COMPUTE, UNLOAD)
//   bin_idx_t            - index of one of the four output bins
package fft4_pkg;

    localparam int IN_W_DEF  = 8;
    localparam int OUT_W_DEF = 16;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    typedef logic [1:0] bin_idx_t;

endpackage

// File: rtl/fft4_core.sv
// fft4_core
// Two-stage registered radix-2 4-point DFT with a fixed latency of 2 cycles.
// Ports:
//   clk, reset            - clock and asynchronous active-high reset
//   in_valid              - x0..x3 are valid this cycle
//   x0..x3                - unsigned input samples (zero-extended internally)
//   out_valid             - bins below are valid this cycle
//   xK_re / xK_im         - the four complex bins, wrapping modulo 2^OUT_W
module fft4_core
    import fft4_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  x0,
    input  logic [IN_W-1:0]  x1,
    input  logic [IN_W-1:0]  x2,
    input  logic [IN_W-1:0]  x3,
    output logic             out_valid,
    output logic [OUT_W-1:0] x0_re,
    output logic [OUT_W-1:0] x0_im,
    output logic [OUT_W-1:0] x1_re,
    output logic [OUT_W-1:0] x1_im,
    output logic [OUT_W-1:0] x2_re,
    output logic [OUT_W-1:0] x2_im,
    output logic [OUT_W-1:0] x3_re,
    output logic [OUT_W-1:0] x3_im
);

    localparam int PAD = OUT_W - IN_W;

    logic [OUT_W-1:0] e0, e1, e2, e3;

    logic             v1_d, v1_q, v2_d, v2_q;
    logic [OUT_W-1:0] sum02_d, sum02_q, dif02_d, dif02_q;
    logic [OUT_W-1:0] sum13_d, sum13_q, dif13_d, dif13_q;
    logic [OUT_W-1:0] x0_re_d, x0_re_q, x2_re_d, x2_re_q;
    logic [OUT_W-1:0] x13_re_d, x13_re_q, x1_im_d, x1_im_q, x3_im_d, x3_im_q;

    assign e0 = {{PAD{1'b0}}, x0};
    assign e1 = {{PAD{1'b0}}, x1};
    assign e2 = {{PAD{1'b0}}, x2};
    assign e3 = {{PAD{1'b0}}, x3};

    // Stage 1 forms the even/odd butterflies; stage 2 combines them.
    // X1 and X3 share the same real part, and the imaginary parts of X0/X2
    // are identically zero, so only five stage-2 registers are needed.
    always_comb begin
        v1_d     = in_valid;
        v2_d     = v1_q;
        sum02_d  = e0 + e2;
        dif02_d  = e0 - e2;
        sum13_d  = e1 + e3;
        dif13_d  = e1 - e3;
        x0_re_d  = sum02_q + sum13_q;
        x2_re_d  = sum02_q - sum13_q;
        x13_re_d = dif02_q;
        x1_im_d  = '0 - dif13_q;
        x3_im_d  = dif13_q;
    end

    // Only the valid bits are reset; the data path is qualified by them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    always_ff @(posedge clk) begin
        sum02_q  <= sum02_d;
        dif02_q  <= dif02_d;
        sum13_q  <= sum13_d;
        dif13_q  <= dif13_d;
        x0_re_q  <= x0_re_d;
        x2_re_q  <= x2_re_d;
        x13_re_q <= x13_re_d;
        x1_im_q  <= x1_im_d;
        x3_im_q  <= x3_im_d;
    end

    assign out_valid = v2_q;
    assign x0_re     = x0_re_q;
    assign x0_im     = '0;
    assign x1_re     = x13_re_q;
    assign x1_im     = x1_im_q;
    assign x2_re     = x2_re_q;
    assign x2_im     = '0;
    assign x3_re     = x13_re_q;
    assign x3_im     = x3_im_q;

endmodule

// File: rtl/fft4_frame_ctrl.sv
// fft4_frame_ctrl
// Collects four samples, runs them through fft4_core and streams the four
// bins out with valid/ready flow control.
// Ports:
//   clk, reset        - clock and asynchronous active-high reset
//   abort             - synchronous discard of the frame in progress
//   s_valid/s_ready   - sample input handshake, s_data the sample
//   m_valid/m_ready   - bin output handshake
//   m_re/m_im         - bin value, m_idx bin index, m_last marks bin 3
//   busy              - a frame is partially loaded or in flight
//   frame_cnt         - completed frames, wrapping at 16 bits
module fft4_frame_ctrl
    import fft4_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_re,
    output logic [OUT_W-1:0] m_im,
    output logic [1:0]       m_idx,
    output logic             m_last,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    state_t           state_d, state_q;
    bin_idx_t         load_cnt_d, load_cnt_q;
    bin_idx_t         m_idx_d, m_idx_q;
    logic [15:0]      frame_cnt_d, frame_cnt_q;

    // Only slots 0..2 are buffered: the 4th sample goes straight into the
    // core on the edge it is accepted, which is what lets COMPUTE be
    // exactly two cycles with the bins ready on the first UNLOAD cycle.
    logic [IN_W-1:0]  samp_d [0:2];
    logic [IN_W-1:0]  samp_q [0:2];
    logic [OUT_W-1:0] bank_re_d [0:3];
    logic [OUT_W-1:0] bank_re_q [0:3];
    logic [OUT_W-1:0] bank_im_d [0:3];
    logic [OUT_W-1:0] bank_im_q [0:3];

    logic             s_hs, m_hs;
    logic             core_in_valid, core_out_valid;
    logic [OUT_W-1:0] c0_re, c0_im, c1_re, c1_im, c2_re, c2_im, c3_re, c3_im;

    assign s_hs = s_valid && (state_q == LOAD);
    assign m_hs = m_ready && (state_q == UNLOAD);

    fft4_core #(
        .IN_W (IN_W),
        .OUT_W(OUT_W)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .in_valid (core_in_valid),
        .x0       (samp_q[0]),
        .x1       (samp_q[1]),
        .x2       (samp_q[2]),
        .x3       (s_data),
        .out_valid(core_out_valid),
        .x0_re    (c0_re),
        .x0_im    (c0_im),
        .x1_re    (c1_re),
        .x1_im    (c1_im),
        .x2_re    (c2_re),
        .x2_im    (c2_im),
        .x3_re    (c3_re),
        .x3_im    (c3_im)
    );

    // Next-state logic. abort overrides everything, including a final bin-3
    // handshake, so an aborted frame never reaches frame_cnt.
    always_comb begin
        state_d       = state_q;
        load_cnt_d    = load_cnt_q;
        m_idx_d       = m_idx_q;
        frame_cnt_d   = frame_cnt_q;
        core_in_valid = 1'b0;
        if (abort) begin
            state_d    = LOAD;
            load_cnt_d = '0;
            m_idx_d    = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (s_hs) begin
                        load_cnt_d = load_cnt_q + 2'd1;
                        if (load_cnt_q == 2'd3) begin
                            state_d       = COMPUTE;
                            core_in_valid = 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (core_out_valid) begin
                        state_d = UNLOAD;
                    end
                end
                UNLOAD: begin
                    if (m_hs) begin
                        if (m_idx_q == 2'd3) begin
                            state_d     = LOAD;
                            load_cnt_d  = '0;
                            m_idx_d     = '0;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                        end else begin
                            m_idx_d = m_idx_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_d    = LOAD;
                    load_cnt_d = '0;
                    m_idx_d    = '0;
                end
            endcase
        end
    end

    // Sample buffer and output bank. A sample coinciding with abort is
    // dropped; the bank is loaded whenever the core delivers a result.
    always_comb begin
        samp_d    = samp_q;
        bank_re_d = bank_re_q;
        bank_im_d = bank_im_q;
        if (s_hs && !abort) begin
            for (int i = 0; i < 3; i++) begin
                if (int'(load_cnt_q) == i) begin
                    samp_d[i] = s_data;
                end
            end
        end
        if (core_out_valid) begin
            bank_re_d[0] = c0_re;
            bank_re_d[1] = c1_re;
            bank_re_d[2] = c2_re;
            bank_re_d[3] = c3_re;
            bank_im_d[0] = c0_im;
            bank_im_d[1] = c1_im;
            bank_im_d[2] = c2_im;
            bank_im_d[3] = c3_im;
        end
    end

    // Control state: reset returns to an empty LOAD with a zero frame count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LOAD;
            load_cnt_q  <= '0;
            m_idx_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            m_idx_q     <= m_idx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Data storage needs no reset; it is always qualified by the FSM.
    always_ff @(posedge clk) begin
        samp_q    <= samp_d;
        bank_re_q <= bank_re_d;
        bank_im_q <= bank_im_d;
    end

    assign s_ready   = (state_q == LOAD);
    assign m_valid   = (state_q == UNLOAD);
    assign m_re      = bank_re_q[m_idx_q];
    assign m_im      = bank_im_q[m_idx_q];
    assign m_idx     = m_idx_q;
    assign m_last    = (m_idx_q == 2'd3);
    assign busy      = (state_q != LOAD) || (load_cnt_q != 2'd0);
    assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/fft4_frame_ctrl.md
FFT4_FRAME_CTRL -- requirements
Module: fft4_frame_ctrl

Interface
REQ-001 Parameter: IN_W, 8, input sample width (unsigned).
REQ-002 Parameter: OUT_W, 16, output real/imag width (two's complement).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-004 Ports SHALL be:
- clk  in  1  clock, all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- abort  in  1  synchronous discard of the frame in progress
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample accepted when high together with s_valid
- s_data  in  IN_W  input sample
- m_valid  out  1  output bin valid
- m_ready  in  1  downstream accepts the bin
- m_re  out  OUT_W  bin real part
- m_im  out  OUT_W  bin imaginary part
- m_idx  out  2  bin index, 0..3
- m_last  out  1  high when m_idx=3
- busy  out  1  high when the state is not LOAD, or load_cnt is not 0
- frame_cnt  out  16  number of completed frames

Function
REQ-005 The FSM SHALL have exactly three states: LOAD, COMPUTE and UNLOAD.
REQ-006 In LOAD, s_ready SHALL be 1, and each handshake (s_valid & s_ready) SHALL store s_data into slot load_cnt, then increment load_cnt.
REQ-007 On the 4th accepted sample, the FSM SHALL move to COMPUTE on the next edge, and s_ready SHALL be 0 from that cycle until the FSM re-enters LOAD.
REQ-008 COMPUTE SHALL last exactly 2 cycles (the two pipeline stages of the core), then the FSM SHALL move to UNLOAD.
REQ-009 Arithmetic: samples SHALL be zero-extended to OUT_W, and all sums SHALL wrap modulo 2^OUT_W.
REQ-010 Bin values SHALL be:
- X0 = x0+x1+x2+x3 + j0
- X1 = (x0-x2) - j(x1-x3)
- X2 = x0-x1+x2-x3 + j0
- X3 = (x0-x2) + j(x1-x3)
REQ-011 In UNLOAD, m_valid SHALL be 1 and m_idx SHALL start at 0; each handshake (m_valid & m_ready) SHALL advance m_idx.
REQ-012 While m_valid=1 and m_ready=0, m_re, m_im, m_idx and m_last SHALL hold stable.
REQ-013 A handshake on bin 3 SHALL, on the same edge: return the FSM to LOAD, clear load_cnt, and increment frame_cnt, with wrap from 0xFFFF to 0.
REQ-014 Minimum frame period SHALL be 10 cycles: 4 load, 2 compute, 4 unload.
REQ-015 m_valid SHALL be 0 outside UNLOAD, and m_re/m_im SHALL be don't-care when m_valid=0.
REQ-016 abort=1 in any state SHALL, on the next edge: force LOAD, clear load_cnt and m_idx, and drop m_valid.
REQ-017 abort SHALL leave frame_cnt unchanged, and a sample handshake coinciding with abort SHALL be discarded.
REQ-018 abort SHALL take priority over every simultaneous handshake, including a final bin-3 handshake, which SHALL then not count as a completed frame.

Reset
REQ-019 On reset, the block SHALL set: state=LOAD, load_cnt=0, m_idx=0, m_valid=0, frame_cnt=0, and pipeline valid bits to 0.
REQ-020 Sample and pipeline data registers SHALL need no reset.
REQ-021 Reset asserted mid-frame SHALL discard all partial data, and after release the block SHALL accept a fresh frame starting with slot 0.

Structure
REQ-022 A shared package fft4_pkg SHALL hold the IN_W/OUT_W defaults, the state enum (LOAD, COMPUTE, UNLOAD) and the bin-index type.
REQ-023 The arithmetic SHALL reside in the sub-module fft4_core, with this behaviour:
- a two-stage registered radix-2 pipeline
- inputs: in_valid and x0..x3
- outputs: out_valid and the 4 complex bins
- a 2-cycle fixed latency
REQ-024 fft4_frame_ctrl SHALL own the FSM, the sample buffer, the output bin register bank and the counters.

Verification
REQ-025 Input samples 1,2,3,4 -> bins in order: X0=10+0j; X1=-2+2j (0xFFFE, 0x0002); X2=-2+0j (0xFFFE, 0x0000); X3=-2-2j (0xFFFE, 0xFFFE); m_last only on X3; frame_cnt=1.
REQ-026 Input samples 255 ×4 with m_ready=1 constant -> X0=1020 (0x03FC)+0j, all other bins 0; m_valid rises exactly 6 cycles after the first sample handshake.
REQ-027 Backpressure: m_ready=0 for 5 cycles while X1 is presented -> X1 held constant with m_idx=1; s_ready=0 throughout; X2 follows the first cycle with m_ready=1.
REQ-028 abort after 2 samples, followed by samples 4,0,0,0 -> X0=4, X1=4, X2=4, X3=4, all imag 0; frame_cnt incremented once only.
REQ-029 Reset pulsed during UNLOAD at m_idx=2 -> m_valid=0, s_ready=1, frame_cnt=0 immediately; the next frame is computed correctly.
REQ-030 65536 back-to-back frames with zero samples -> frame_cnt wraps to 0, and no cycle is lost between frames (period 10).
